// File: rtl/fp_mult_pkg.sv
// ---------------------------------------------------------------------------
// fp_mult_pkg
// Shared definitions for the FP multiply datapath's iterative mantissa
// multiplier: the controller state encoding and the helpers that size the
// iteration counter from WIDTH / DIGIT_BITS.
// No ports (package).
// ---------------------------------------------------------------------------
package fp_mult_pkg;

  // Controller states of the sequential multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default single-precision configuration (24-bit mantissa incl. hidden bit).
  localparam int DEF_WIDTH      = 24;
  localparam int DEF_DIGIT_BITS = 4;

  // Integer ceiling division; used for the full-latency iteration count.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Iteration counter width: clog2(n), never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_digit_pp.sv
// ---------------------------------------------------------------------------
// mult_digit_pp
// Purely combinational WIDTH x DIGIT_BITS unsigned partial-product generator.
// Forms a * digit exactly as the sum of shifted copies of a, one row per
// digit bit.
// Ports:
//   a      in   WIDTH               multiplicand
//   digit  in   DIGIT_BITS          multiplier digit
//   pp     out  WIDTH+DIGIT_BITS    exact product a * digit
// ---------------------------------------------------------------------------
module mult_digit_pp #(
  parameter int WIDTH      = 24,
  parameter int DIGIT_BITS = 4
) (
  input  logic [WIDTH-1:0]            a,
  input  logic [DIGIT_BITS-1:0]       digit,
  output logic [WIDTH+DIGIT_BITS-1:0] pp
);

  localparam int PPW = WIDTH + DIGIT_BITS;

  logic [PPW-1:0] rows [DIGIT_BITS];
  logic [PPW-1:0] row_sum;

  // One gated, shifted copy of the multiplicand per digit bit.
  generate
    for (genvar gi = 0; gi < DIGIT_BITS; gi++) begin : g_row
      assign rows[gi] = digit[gi] ? (PPW'(a) << gi) : '0;
    end
  endgenerate

  // Sum of rows; PPW bits hold the full product so no carry is lost.
  always_comb begin
    row_sum = '0;
    for (int i = 0; i < DIGIT_BITS; i++) begin
      row_sum = row_sum + rows[i];
    end
  end

  assign pp = row_sum;

endmodule

// File: rtl/seq_mantissa_multiplier.sv
// ---------------------------------------------------------------------------
// seq_mantissa_multiplier
// Iterative unsigned mantissa multiplier: Mr = M1 * M2 (exact, 2*WIDTH bits).
// DIGIT_BITS bits of M2 are consumed per BUSY cycle, least significant digit
// first. Valid/ready handshakes on both sides; a new operand pair can be
// accepted in the same edge that the previous product is handed off.
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous, active-high reset
//   in_valid   in   1          operands valid
//   in_ready   out  1          block can accept operands
//   M1         in   WIDTH      multiplicand, unsigned
//   M2         in   WIDTH      multiplier, unsigned
//   out_valid  out  1          Mr holds a completed product
//   out_ready  in   1          consumer accepts Mr
//   Mr         out  2*WIDTH    product M1*M2
//   busy       out  1          high while iterating
// ---------------------------------------------------------------------------
module seq_mantissa_multiplier
  import fp_mult_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DIGIT_BITS = DEF_DIGIT_BITS,
  parameter int EARLY_TERM = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     M1,
  input  logic [WIDTH-1:0]     M2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Mr,
  output logic                 busy
);

  localparam int N  = ceil_div(WIDTH, DIGIT_BITS);  // full-latency iterations
  localparam int CW = cnt_width(N);                 // iteration counter width
  localparam int PW = N * DIGIT_BITS;               // M2 padded to whole digits
  localparam int AW = 2 * WIDTH;                    // accumulator width
  localparam int SW = $clog2(AW);                   // digit shift amount width

  state_t                     state_reg, state_next;
  logic [WIDTH-1:0]           m1_reg;
  logic [PW-1:0]              m2_reg;   // shifted right one digit per BUSY cycle
  logic [AW-1:0]              acc_reg;
  logic [AW-1:0]              acc_next;
  logic [AW-1:0]              mr_reg;
  logic [CW-1:0]              k_reg;
  logic [WIDTH+DIGIT_BITS-1:0] pp;
  logic [SW-1:0]              shamt;
  logic                       rest_zero;
  logic                       last_digit;
  logic                       accept;

  // Current digit always sits in the low DIGIT_BITS of m2_reg; the zero
  // padding above M2[WIDTH-1] supplies the zero-extension of a short last
  // digit.
  mult_digit_pp #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (DIGIT_BITS)
  ) u_pp (
    .a     (m1_reg),
    .digit (m2_reg[DIGIT_BITS-1:0]),
    .pp    (pp)
  );

  // Weight of digit k is 2^(k*DIGIT_BITS); max shift stays below WIDTH.
  assign shamt    = SW'(k_reg) * SW'(DIGIT_BITS);
  assign acc_next = acc_reg + (AW'(pp) << shamt);

  // Nothing left to multiply once the bits above the current digit are zero.
  assign rest_zero  = ((m2_reg >> DIGIT_BITS) == '0);
  assign last_digit = (k_reg == CW'(N - 1)) || ((EARLY_TERM != 0) && rest_zero);

  assign accept = in_valid & in_ready;

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        // Handoff edge doubles as an accept edge when new operands wait.
        if (out_ready) state_next = in_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs -------------------------------------------------------
  // in_ready depends on state and out_ready only, never on in_valid.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      BUSY: busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // ---- Datapath: operand latch, shift/accumulate, result register ---------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_reg  <= '0;
      m2_reg  <= '0;
      acc_reg <= '0;
      k_reg   <= '0;
      mr_reg  <= '0;
    end else if (accept) begin
      m1_reg  <= M1;
      m2_reg  <= PW'(M2);
      acc_reg <= '0;
      k_reg   <= '0;
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_next;
      m2_reg  <= m2_reg >> DIGIT_BITS;
      k_reg   <= k_reg + CW'(1);
      // Mr is loaded on the DONE-entry edge and held until the next one.
      if (last_digit) mr_reg <= acc_next;
    end
  end

  assign Mr = mr_reg;

endmodule
